// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the control unit and the MULT/DIV engine
interface mult_div_if #(parameter int WIDTH = 32);
  logic mult_start, div_start;
  logic [WIDTH-1:0] a_in, b_in;
  logic busy, done, div_zero;
  logic [WIDTH-1:0] hi_out, lo_out;
  modport master(output mult_start, div_start, a_in, b_in, input busy, done, div_zero, hi_out, lo_out);
  modport slave(input mult_start, div_start, a_in, b_in, output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed radix-2 Booth multiplier and restoring divider writing HI/LO
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset,
  mult_div_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t r_state;
  logic [CW-1:0] r_count;
  logic [2*WIDTH:0] r_p;
  logic [WIDTH-1:0] r_m, r_rem, r_quo, r_hi, r_lo;
  logic r_neg_q, r_neg_r, r_busy, r_done, r_div_zero;
  logic [WIDTH:0] w_upper, w_booth_sum, w_trial, w_diff;
  logic [2*WIDTH:0] w_p_next;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_next, w_quo_next;
  logic w_last;
  // Booth partial sum kept one bit wider so the shift uses the true sign even for -2^(W-1)
  assign w_upper = {r_p[2*WIDTH], r_p[2*WIDTH:WIDTH+1]};
  assign w_booth_sum = (r_p[1:0] == 2'b01) ? w_upper + {r_m[WIDTH-1], r_m}
                     : (r_p[1:0] == 2'b10) ? w_upper - {r_m[WIDTH-1], r_m} : w_upper;
  assign w_p_next = {w_booth_sum, r_p[WIDTH:1]};
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_trial - {1'b0, r_m};
  assign w_rem_next = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_a_mag = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign w_b_mag = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign w_last = r_count == CW'(WIDTH - 1);
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_p <= '0;
      r_m <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mult_start) begin
            r_p <= {{WIDTH{1'b0}}, bus.b_in, 1'b0};
            r_m <= bus.a_in;
            r_count <= '0;
            r_busy <= 1'b1;
            r_state <= MULT;
          end else if (bus.div_start && bus.b_in == '0) begin
            r_div_zero <= 1'b1;
          end else if (bus.div_start) begin
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_m <= w_b_mag;
            r_neg_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            r_neg_r <= bus.a_in[WIDTH-1];
            r_count <= '0;
            r_busy <= 1'b1;
            r_state <= DIV;
          end
        end
        MULT: begin
          r_p <= w_p_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_hi <= w_p_next[2*WIDTH:WIDTH+1];
            r_lo <= w_p_next[WIDTH:1];
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_count <= r_count + 1'b1;
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_hi <= r_neg_r ? -r_rem : r_rem;
          r_lo <= r_neg_q ? -r_quo : r_quo;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
